// File: rtl/segmented_bram_buffer.sv
// Multi-segment block-RAM buffer: 16-bit host words are packed into wide entries on the write side,
// and a fixed two-cycle read comes from the active segment, which changes only through a handshaked swap.
module segmented_bram_buffer #(
  parameter int DATA_WIDTH   = 128,
  parameter int DEPTH        = 1024,
  parameter int NUM_SEGMENTS = 2,
  localparam int SEG_W = (NUM_SEGMENTS > 2) ? 2 : 1,
  localparam int LANES = DATA_WIDTH / 16,
  localparam int RD_AW = $clog2(DEPTH),
  localparam int WR_AW = $clog2(DEPTH * LANES)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WR_EN,
  input  logic [SEG_W-1:0]      WR_SEGMENT,
  input  logic [WR_AW-1:0]      WR_ADDR,
  input  logic [15:0]           WR_DATA,
  input  logic                  WR_LOCK,
  output logic                  WR_REJECT,
  input  logic [RD_AW-1:0]      RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_VALUE,
  output logic [SEG_W-1:0]      RD_SEGMENT,
  input  logic                  SWAP_REQ,
  input  logic [SEG_W-1:0]      SWAP_SEG,
  input  logic                  SWAP_AT_WRAP,
  output logic                  SWAP_PENDING,
  output logic                  SWAP_DONE
);

  localparam int LANE_BITS   = $clog2(LANES);
  localparam int LANE_W      = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int MEM_AW      = SEG_W + RD_AW;
  localparam int MEM_ENTRIES = NUM_SEGMENTS * DEPTH;
  localparam bit SEG_FULL    = (NUM_SEGMENTS == (1 << SEG_W));
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  typedef enum logic {IDLE, PENDING} swap_state_t;

  logic [LANE_W-1:0]     wr_lane;
  logic [RD_AW-1:0]      wr_entry;
  logic                  wr_seg_ok;
  logic                  swap_seg_ok;
  logic                  wr_reject_now;
  logic                  wr_accept;
  logic                  wr_commit;
  logic [MEM_AW-1:0]     wr_index;
  logic [MEM_AW-1:0]     rd_index;
  logic [DATA_WIDTH-1:0] commit_word;
  logic [15:0]           lane_reg [LANES];
  logic [DATA_WIDTH-1:0] mem [MEM_ENTRIES];
  logic [DATA_WIDTH-1:0] mem_q_reg;
  swap_state_t           state_reg;
  logic [SEG_W-1:0]      target_reg;
  logic [RD_AW-1:0]      prev_addr_reg;
  logic                  wrap;
  logic                  swap_valid;

  assign wr_lane  = LANE_W'(32'(WR_ADDR) % LANES);
  assign wr_entry = RD_AW'(32'(WR_ADDR) / LANES);

  // With a power-of-two segment count every encodable segment index exists.
  generate
    if (SEG_FULL) begin : g_seg_full
      assign wr_seg_ok   = 1'b1;
      assign swap_seg_ok = 1'b1;
    end else begin : g_seg_part
      localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(NUM_SEGMENTS - 1);
      assign wr_seg_ok   = (WR_SEGMENT <= SEG_LAST);
      assign swap_seg_ok = (SWAP_SEG <= SEG_LAST);
    end
  endgenerate

  assign wr_reject_now = WR_EN && ((WR_LOCK && (WR_SEGMENT == RD_SEGMENT)) || !wr_seg_ok);
  assign wr_accept     = WR_EN && !wr_reject_now;
  assign wr_commit     = wr_accept && (wr_lane == LANE_LAST);
  assign wr_index      = {WR_SEGMENT, wr_entry};
  assign rd_index      = {RD_SEGMENT, RD_ADDR};

  // The top lane is taken straight from the bus so the entry commits on its final word.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_commit
      if (gi == LANES - 1) begin : g_top
        assign commit_word[gi*16 +: 16] = WR_DATA;
      end else begin : g_low
        assign commit_word[gi*16 +: 16] = lane_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < LANES; i++) begin
        lane_reg[i] <= '0;
      end
    end else if (wr_accept) begin
      lane_reg[wr_lane] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      WR_REJECT <= 1'b0;
    end else begin
      WR_REJECT <= wr_reject_now;
    end
  end

  // Memory has no reset so it maps onto block RAM; a same-edge read sees the old entry.
  always_ff @(posedge CLK) begin
    if (wr_commit) begin
      mem[wr_index] <= commit_word;
    end
    mem_q_reg <= mem[rd_index];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      RD_VALUE <= '0;
    end else begin
      RD_VALUE <= mem_q_reg;
    end
  end

  assign wrap       = (RD_ADDR == '0) && (prev_addr_reg != '0);
  assign swap_valid = SWAP_REQ && swap_seg_ok;

  // A fresh valid request always takes priority over a wrap landing on the same edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg     <= IDLE;
      target_reg    <= '0;
      prev_addr_reg <= '0;
      RD_SEGMENT    <= '0;
      SWAP_PENDING  <= 1'b0;
      SWAP_DONE     <= 1'b0;
    end else begin
      prev_addr_reg <= RD_ADDR;
      SWAP_DONE     <= 1'b0;
      if (swap_valid) begin
        if (!SWAP_AT_WRAP) begin
          RD_SEGMENT   <= SWAP_SEG;
          SWAP_DONE    <= 1'b1;
          SWAP_PENDING <= 1'b0;
          state_reg    <= IDLE;
        end else begin
          target_reg   <= SWAP_SEG;
          SWAP_PENDING <= 1'b1;
          state_reg    <= PENDING;
        end
      end else begin
        case (state_reg)
          PENDING: begin
            if (wrap) begin
              RD_SEGMENT   <= target_reg;
              SWAP_DONE    <= 1'b1;
              SWAP_PENDING <= 1'b0;
              state_reg    <= IDLE;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_segmented_bram_buffer.sv
// Directed bench for segmented_bram_buffer: packing, write rejects, read latency,
// immediate and wrap-deferred swaps, and reset while a swap is pending.
module tb_segmented_bram_buffer;

  localparam int DW    = 128;
  localparam int DEPTH = 1024;
  localparam int NSEG  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [1:0]    wr_segment;
  logic [12:0]   wr_addr;
  logic [15:0]   wr_data;
  logic          wr_lock;
  logic          wr_reject;
  logic [9:0]    rd_addr;
  logic [DW-1:0] rd_value;
  logic [1:0]    rd_segment;
  logic          swap_req;
  logic [1:0]    swap_seg;
  logic          swap_at_wrap;
  logic          swap_pending;
  logic          swap_done;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  segmented_bram_buffer #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .NUM_SEGMENTS(NSEG)
  ) dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .WR_EN       (wr_en),
    .WR_SEGMENT  (wr_segment),
    .WR_ADDR     (wr_addr),
    .WR_DATA     (wr_data),
    .WR_LOCK     (wr_lock),
    .WR_REJECT   (wr_reject),
    .RD_ADDR     (rd_addr),
    .RD_VALUE    (rd_value),
    .RD_SEGMENT  (rd_segment),
    .SWAP_REQ    (swap_req),
    .SWAP_SEG    (swap_seg),
    .SWAP_AT_WRAP(swap_at_wrap),
    .SWAP_PENDING(swap_pending),
    .SWAP_DONE   (swap_done)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [1:0] seg, input logic [12:0] addr, input logic [15:0] data);
    wr_en      = 1'b1;
    wr_segment = seg;
    wr_addr    = addr;
    wr_data    = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wr_entry(input logic [1:0] seg, input int entry, input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      wr_word(seg, 13'(entry * 8 + i), base + 16'(i));
    end
  endtask

  function automatic logic [127:0] entry_val(input logic [15:0] base);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v[i*16 +: 16] = base + 16'(i);
    end
    return v;
  endfunction

  task automatic swap(input logic [1:0] seg, input logic at_wrap);
    swap_req     = 1'b1;
    swap_seg     = seg;
    swap_at_wrap = at_wrap;
    step();
    swap_req = 1'b0;
  endtask

  task automatic read_after2(input string tag, input logic [9:0] addr, input logic [127:0] exp);
    rd_addr = addr;
    step();
    step();
    check_eq(tag, rd_value, exp);
  endtask

  initial begin
    logic [127:0] seg1_e0;
    logic [127:0] half_entry;
    int viol;

    rst_n = 1'b0; wr_en = 1'b0; wr_segment = '0; wr_addr = '0; wr_data = '0;
    wr_lock = 1'b0; rd_addr = '0; swap_req = 1'b0; swap_seg = '0; swap_at_wrap = 1'b0;
    repeat (3) step();
    check_eq("rst_rd_segment", 128'(rd_segment), 128'd0);
    check_eq("rst_rd_value", rd_value, 128'd0);
    check_eq("rst_pending", 128'(swap_pending), 128'd0);
    check_eq("rst_done", 128'(swap_done), 128'd0);
    check_eq("rst_reject", 128'(wr_reject), 128'd0);
    rst_n = 1'b1;
    step();

    // Fill: the last entry written leaves lanes holding 0x5000..0x5007
    wr_entry(2'd0, 0, 16'h1000);
    wr_entry(2'd1, 1, 16'h2000);
    wr_entry(2'd2, 0, 16'h3000);
    wr_entry(2'd1, 1023, 16'h6000);
    wr_entry(2'd0, 1, 16'h5000);
    check_eq("wr_no_reject", 128'(wr_reject), 128'd0);

    // Two-cycle read latency
    rd_addr = 10'd1;
    step(); step();
    check_eq("rd_s0_e1", rd_value, entry_val(16'h5000));
    rd_addr = 10'd0;
    step();
    check_eq("rd_latency_hold", rd_value, entry_val(16'h5000));
    step();
    check_eq("rd_s0_e0", rd_value, 128'h1007_1006_1005_1004_1003_1002_1001_1000);

    // Locked writes to the active segment are dropped
    wr_lock = 1'b1;
    wr_word(2'd0, 13'd0, 16'hDEAD);
    check_eq("rej_lock_pulse", 128'(wr_reject), 128'd1);
    step();
    check_eq("rej_lock_clear", 128'(wr_reject), 128'd0);
    wr_word(2'd0, 13'd7, 16'hBEEF);
    check_eq("rej_commit_pulse", 128'(wr_reject), 128'd1);
    read_after2("rej_entry_kept", 10'd0, entry_val(16'h1000));
    wr_word(2'd1, 13'd7, 16'hBEEF);
    check_eq("lock_other_seg", 128'(wr_reject), 128'd0);
    wr_lock = 1'b0;
    wr_word(2'd3, 13'd7, 16'h1234);
    check_eq("rej_seg_range", 128'(wr_reject), 128'd1);
    step();
    seg1_e0 = entry_val(16'h5000);
    seg1_e0[127:112] = 16'hBEEF;

    // Immediate swap
    swap(2'd1, 1'b0);
    check_eq("imm_segment", 128'(rd_segment), 128'd1);
    check_eq("imm_done", 128'(swap_done), 128'd1);
    check_eq("imm_pending", 128'(swap_pending), 128'd0);
    step();
    check_eq("imm_done_clear", 128'(swap_done), 128'd0);
    read_after2("rd_s1_e0", 10'd0, seg1_e0);
    read_after2("rd_s1_e1", 10'd1, entry_val(16'h2000));

    // Deferred swap across a full sweep
    rd_addr = 10'd5;
    step();
    swap(2'd0, 1'b1);
    check_eq("defer_pending", 128'(swap_pending), 128'd1);
    check_eq("defer_segment", 128'(rd_segment), 128'd1);
    viol = 0;
    for (int a = 6; a < DEPTH; a++) begin
      rd_addr = 10'(a);
      step();
      if (swap_pending !== 1'b1 || rd_segment !== 2'd1 || swap_done !== 1'b0) viol++;
    end
    check_eq("sweep_hold", 128'(viol), 128'd0);
    rd_addr = 10'd0;
    step();
    check_eq("wrap_segment", 128'(rd_segment), 128'd0);
    check_eq("wrap_done", 128'(swap_done), 128'd1);
    check_eq("wrap_pending", 128'(swap_pending), 128'd0);
    check_eq("rd_1023_old", rd_value, entry_val(16'h6000));
    step();
    check_eq("wrap_done_clear", 128'(swap_done), 128'd0);

    // Three segments: bad index ignored, last deferred request wins
    swap(2'd3, 1'b0);
    check_eq("bad_seg_segment", 128'(rd_segment), 128'd0);
    check_eq("bad_seg_done", 128'(swap_done), 128'd0);
    rd_addr = 10'd5;
    step();
    swap(2'd1, 1'b1);
    swap(2'd2, 1'b1);
    swap(2'd3, 1'b1);
    check_eq("retarget_pending", 128'(swap_pending), 128'd1);
    check_eq("retarget_segment", 128'(rd_segment), 128'd0);
    rd_addr = 10'd0;
    step();
    check_eq("wrap_last_wins", 128'(rd_segment), 128'd2);
    check_eq("wrap_last_done", 128'(swap_done), 128'd1);

    // Immediate request cancels a pending one
    rd_addr = 10'd5;
    step();
    swap(2'd1, 1'b1);
    swap(2'd0, 1'b0);
    check_eq("imm_over_pend_seg", 128'(rd_segment), 128'd0);
    check_eq("imm_over_pend_flag", 128'(swap_pending), 128'd0);
    check_eq("imm_over_pend_done", 128'(swap_done), 128'd1);
    rd_addr = 10'd0;
    step();
    check_eq("no_stale_wrap_seg", 128'(rd_segment), 128'd0);
    check_eq("no_stale_wrap_done", 128'(swap_done), 128'd0);
    swap(2'd0, 1'b0);
    check_eq("same_seg_done", 128'(swap_done), 128'd1);

    // Wrap and new deferred request on one edge: the request wins
    rd_addr = 10'd5;
    step();
    swap(2'd1, 1'b1);
    rd_addr = 10'd0;
    swap(2'd2, 1'b1);
    check_eq("wrap_vs_req_seg", 128'(rd_segment), 128'd0);
    check_eq("wrap_vs_req_pend", 128'(swap_pending), 128'd1);
    check_eq("wrap_vs_req_done", 128'(swap_done), 128'd0);
    rd_addr = 10'd5;
    step();
    rd_addr = 10'd0;
    step();
    check_eq("wrap_vs_req_apply", 128'(rd_segment), 128'd2);

    // Reset with a pending swap and a half-packed entry
    for (int i = 0; i < 4; i++) wr_word(2'd1, 13'(16 + i), 16'hA000 + 16'(i));
    rd_addr = 10'd5;
    step();
    swap(2'd0, 1'b1);
    check_eq("pre_rst_pending", 128'(swap_pending), 128'd1);
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_segment", 128'(rd_segment), 128'd0);
    check_eq("mid_rst_value", rd_value, 128'd0);
    check_eq("mid_rst_pending", 128'(swap_pending), 128'd0);
    check_eq("mid_rst_done", 128'(swap_done), 128'd0);
    check_eq("mid_rst_reject", 128'(wr_reject), 128'd0);
    rst_n = 1'b1;
    step();
    rd_addr = 10'd0;
    step();
    check_eq("post_rst_no_wrap", 128'(swap_done), 128'd0);
    half_entry = '0;
    for (int i = 4; i < 8; i++) begin
      wr_word(2'd1, 13'(16 + i), 16'hB000 + 16'(i));
      half_entry[i*16 +: 16] = 16'hB000 + 16'(i);
    end
    read_after2("mem_retained", 10'd0, entry_val(16'h1000));
    swap(2'd1, 1'b0);
    read_after2("lane_cleared", 10'd2, half_entry);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
